stream_deintplator: RTL and testbench

- Streaming, handshaked successor to the RX combinational resampler.
- Accepts one complex interpolated sample per beat and keeps every FACTOR-th sample, starting at a programmable phase.
- Emits TOTAL_SAMPLES decimated complex samples per frame, with start-of-frame and end-of-frame markers.
- Sits between the RX interpolator/filter chain and the SC-FDMA demodulator. Factor and phase are runtime-selectable per frame.

---
 rtl/rx_pkg.sv | 23 ++
 rtl/rx_out_reg.sv | 47 ++++
 rtl/stream_deintplator.sv | 170 +++++++++++++++++
 tb/tb_stream_deintplator.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
package rx_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH    = 16;
  localparam int unsigned DEFAULT_TOTAL_SAMPLES = 16;
  localparam int unsigned DEFAULT_INT_FACTOR    = 8;

  typedef struct packed {
    logic signed [DEFAULT_DATA_WIDTH-1:0] re;
    logic signed [DEFAULT_DATA_WIDTH-1:0] im;
  } cplx_t;

  typedef enum logic {
    IDLE,
    RUN
  } deint_state_e;

  function automatic logic cfg_legal(input int unsigned factor,
                                     input int unsigned phase,
                                     input int unsigned max_factor);
    return (factor != 0) && (factor <= max_factor) && (phase < factor);
  endfunction

endpackage

// File: rtl/rx_out_reg.sv
module rx_out_reg
  import rx_pkg::*;
#(
  parameter type T = cplx_t
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_valid,
  input  T     i_data,
  input  logic i_sof,
  input  logic i_eof,
  output logic o_ready,
  output logic o_valid,
  input  logic i_ready,
  output T     o_data,
  output logic o_sof,
  output logic o_eof
);

  logic r_valid;
  T     r_data;
  logic r_sof;
  logic r_eof;

  assign o_ready = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_sof   = r_sof;
  assign o_eof   = r_eof;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sof   <= 1'b0;
      r_eof   <= 1'b0;
    end else if (i_valid && o_ready) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_sof   <= i_sof;
      r_eof   <= i_eof;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_deintplator.sv
module stream_deintplator
  import rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int unsigned TOTAL_SAMPLES = DEFAULT_TOTAL_SAMPLES,
  parameter int unsigned MAX_FACTOR    = DEFAULT_INT_FACTOR,
  parameter int unsigned FACTOR_W      = $clog2(MAX_FACTOR) + 1,
  parameter int unsigned CNT_W         = $clog2(TOTAL_SAMPLES * MAX_FACTOR)
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [FACTOR_W-1:0]          i_factor,
  input  logic [FACTOR_W-1:0]          i_phase,
  input  logic                         i_valid,
  input  logic                         i_sof,
  input  logic signed [DATA_WIDTH-1:0] i_re,
  input  logic signed [DATA_WIDTH-1:0] i_im,
  output logic                         o_ready,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic signed [DATA_WIDTH-1:0] o_re,
  output logic signed [DATA_WIDTH-1:0] o_im,
  output logic                         o_sof,
  output logic                         o_eof,
  output logic                         o_err
);

  localparam int unsigned IDX_W = (TOTAL_SAMPLES > 1) ? $clog2(TOTAL_SAMPLES) : 1;
  localparam int unsigned LEN_W = CNT_W + 1;

  typedef struct packed {
    logic signed [DATA_WIDTH-1:0] re;
    logic signed [DATA_WIDTH-1:0] im;
  } sample_t;

  deint_state_e        r_state;
  deint_state_e        w_state_nx;
  logic [FACTOR_W-1:0] r_factor;
  logic [FACTOR_W-1:0] w_factor_nx;
  logic [FACTOR_W-1:0] r_phase;
  logic [FACTOR_W-1:0] w_phase_nx;
  logic [FACTOR_W-1:0] r_phase_cnt;
  logic [FACTOR_W-1:0] w_phase_cnt_nx;
  logic [CNT_W-1:0]    r_in_cnt;
  logic [CNT_W-1:0]    w_in_cnt_nx;
  logic [IDX_W-1:0]    r_out_idx;
  logic [IDX_W-1:0]    w_out_idx_nx;
  logic                r_err;
  logic                w_err;

  logic                w_ready;
  logic                w_accept;
  logic                w_legal;
  logic                w_keep;
  logic                w_keep_sof;
  logic                w_keep_eof;
  logic [LEN_W-1:0]    w_new_len;
  logic [LEN_W-1:0]    w_cur_len;
  sample_t             w_in_data;
  sample_t             w_out_data;

  assign w_accept       = i_valid && w_ready;
  assign w_legal        = cfg_legal(32'(i_factor), 32'(i_phase), MAX_FACTOR);
  assign w_new_len      = LEN_W'(TOTAL_SAMPLES) * LEN_W'(i_factor);
  assign w_cur_len      = LEN_W'(TOTAL_SAMPLES) * LEN_W'(r_factor);
  assign w_in_data.re   = i_re;
  assign w_in_data.im   = i_im;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_factor    <= '0;
      r_phase     <= '0;
      r_phase_cnt <= '0;
      r_in_cnt    <= '0;
      r_out_idx   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_factor    <= w_factor_nx;
      r_phase     <= w_phase_nx;
      r_phase_cnt <= w_phase_cnt_nx;
      r_in_cnt    <= w_in_cnt_nx;
      r_out_idx   <= w_out_idx_nx;
      r_err       <= w_err;
    end
  end

  // A SOF beat is handled identically in IDLE and RUN (restart from this beat);
  // RUN only adds the error pulse for the abandoned frame.
  always_comb begin
    w_state_nx     = r_state;
    w_factor_nx    = r_factor;
    w_phase_nx     = r_phase;
    w_phase_cnt_nx = r_phase_cnt;
    w_in_cnt_nx    = r_in_cnt;
    w_out_idx_nx   = r_out_idx;
    w_err          = 1'b0;
    w_keep         = 1'b0;
    w_keep_sof     = 1'b0;
    w_keep_eof     = 1'b0;

    if (w_accept) begin
      if (i_sof) begin
        w_err = (r_state == RUN) || !w_legal;
        if (w_legal) begin
          w_factor_nx = i_factor;
          w_phase_nx  = i_phase;
          w_keep      = (i_phase == '0);
          w_keep_sof  = w_keep;
          w_keep_eof  = w_keep && (TOTAL_SAMPLES == 1);
          if (w_new_len == LEN_W'(1)) begin
            w_state_nx     = IDLE;
            w_phase_cnt_nx = '0;
            w_in_cnt_nx    = '0;
            w_out_idx_nx   = '0;
          end else begin
            w_state_nx     = RUN;
            w_in_cnt_nx    = CNT_W'(1);
            w_phase_cnt_nx = (i_factor == FACTOR_W'(1)) ? '0 : FACTOR_W'(1);
            w_out_idx_nx   = w_keep ? IDX_W'(1) : '0;
          end
        end else begin
          w_state_nx     = IDLE;
          w_phase_cnt_nx = '0;
          w_in_cnt_nx    = '0;
          w_out_idx_nx   = '0;
        end
      end else if (r_state == RUN) begin
        w_keep     = (r_phase_cnt == r_phase);
        w_keep_sof = w_keep && (r_out_idx == '0);
        w_keep_eof = w_keep && (r_out_idx == IDX_W'(TOTAL_SAMPLES - 1));
        if ({1'b0, r_in_cnt} == w_cur_len - LEN_W'(1)) begin
          w_state_nx     = IDLE;
          w_phase_cnt_nx = '0;
          w_in_cnt_nx    = '0;
          w_out_idx_nx   = '0;
        end else begin
          w_in_cnt_nx    = r_in_cnt + CNT_W'(1);
          w_phase_cnt_nx = (r_phase_cnt == r_factor - FACTOR_W'(1)) ? '0
                                                                     : r_phase_cnt + FACTOR_W'(1);
          w_out_idx_nx   = w_keep ? r_out_idx + IDX_W'(1) : r_out_idx;
        end
      end
    end
  end

  rx_out_reg #(
    .T(sample_t)
  ) u_out_reg (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_valid(w_keep),
    .i_data (w_in_data),
    .i_sof  (w_keep_sof),
    .i_eof  (w_keep_eof),
    .o_ready(w_ready),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_data (w_out_data),
    .o_sof  (o_sof),
    .o_eof  (o_eof)
  );

  assign o_ready = w_ready;
  assign o_re    = w_out_data.re;
  assign o_im    = w_out_data.im;
  assign o_err   = r_err;

endmodule

// File: tb/tb_stream_deintplator.sv
module tb_stream_deintplator;

  localparam int DW = 16;
  localparam int TS = 16;
  localparam int MF = 8;
  localparam int FW = 4;

  logic                 i_clk = 1'b0;
  logic                 i_rst;
  logic [FW-1:0]        i_factor;
  logic [FW-1:0]        i_phase;
  logic                 i_valid;
  logic                 i_sof;
  logic signed [DW-1:0] i_re;
  logic signed [DW-1:0] i_im;
  logic                 o_ready;
  logic                 o_valid;
  logic                 i_ready;
  logic signed [DW-1:0] o_re;
  logic signed [DW-1:0] o_im;
  logic                 o_sof;
  logic                 o_eof;
  logic                 o_err;

  stream_deintplator #(
    .DATA_WIDTH   (DW),
    .TOTAL_SAMPLES(TS),
    .MAX_FACTOR   (MF)
  ) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_factor(i_factor),
    .i_phase (i_phase),
    .i_valid (i_valid),
    .i_sof   (i_sof),
    .i_re    (i_re),
    .i_im    (i_im),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_re    (o_re),
    .o_im    (o_im),
    .o_sof   (o_sof),
    .o_eof   (o_eof),
    .o_err   (o_err)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    bit            sof;
    bit            eof;
  } exp_t;

  exp_t q[$];

  // Reference frame view: beat index k within the active frame.
  bit m_active = 1'b0;
  int m_k      = 0;
  int m_f      = 1;
  int m_ph     = 0;
  bit exp_err  = 1'b0;

  // 0: always ready, 1: toggle, 2: random, 3: stalled
  int ready_mode = 0;

  initial begin
    i_ready = 1'b1;
    forever begin
      @(posedge i_clk);
      #1;
      case (ready_mode)
        0:       i_ready = 1'b1;
        1:       i_ready = ~i_ready;
        2:       i_ready = 1'($urandom_range(0, 1));
        default: i_ready = 1'b0;
      endcase
    end
  end

  always @(negedge i_clk) begin
    int n;
    if (i_rst) begin
      q.delete();
      m_active = 1'b0;
      exp_err  = 1'b0;
    end else begin
      checks++;
      if (o_err !== exp_err) begin
        errors++;
        $display("FAIL err_pulse t=%0t actual=%0b required=%0b", $time, o_err, exp_err);
      end
      exp_err = 1'b0;
      if (i_valid && o_ready) begin
        if (i_sof) begin
          if (m_active) exp_err = 1'b1;
          if (i_factor == 0 || i_factor > MF || i_phase >= i_factor) begin
            exp_err  = 1'b1;
            m_active = 1'b0;
          end else begin
            m_active = 1'b1;
            m_f      = int'(i_factor);
            m_ph     = int'(i_phase);
            m_k      = 0;
          end
        end
        if (m_active) begin
          if (m_k % m_f == m_ph) begin
            n = (m_k - m_ph) / m_f;
            q.push_back('{re: i_re, im: i_im, sof: (n == 0), eof: (n == TS - 1)});
          end
          m_k++;
          if (m_k == TS * m_f) m_active = 1'b0;
        end
      end
    end
  end

  always @(negedge i_clk) begin
    if (!i_rst) begin
      checks++;
      if (o_ready !== (!o_valid || i_ready)) begin
        errors++;
        $display("FAIL ready_rule t=%0t actual=%0b required=%0b", $time, o_ready, (!o_valid || i_ready));
      end
      if (o_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output t=%0t actual re=%0d sof=%0b eof=%0b required=no output",
                   $time, o_re, o_sof, o_eof);
        end else begin
          if ({o_re, o_im, o_sof, o_eof} !== {q[0].re, q[0].im, q[0].sof, q[0].eof}) begin
            errors++;
            $display("FAIL output_sample t=%0t actual re=%0d im=%0d sof=%0b eof=%0b required re=%0d im=%0d sof=%0b eof=%0b",
                     $time, o_re, o_im, o_sof, o_eof, $signed(q[0].re), $signed(q[0].im), q[0].sof, q[0].eof);
          end
          if (i_ready) void'(q.pop_front());
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    i_sof   = 1'b0;
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic drive_beat(input logic [DW-1:0] re, input logic [DW-1:0] im,
                            input bit sof, input int fac, input int ph);
    int unsigned w = 0;
    i_valid = 1'b1;
    i_re    = re;
    i_im    = im;
    i_sof   = sof;
    if (sof) begin
      i_factor = FW'(fac);
      i_phase  = FW'(ph);
    end else begin
      i_factor = FW'($urandom);
      i_phase  = FW'($urandom);
    end
    forever begin
      @(negedge i_clk);
      if (o_ready) break;
      w++;
      if (w > 100) begin
        checks++;
        errors++;
        $display("FAIL beat_accept_timeout actual=not accepted required=accepted within 100 cycles");
        break;
      end
    end
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_sof   = 1'b0;
  endtask

  task automatic send_frame(input int fac, input int ph, input int nbeats,
                            input int gapmax, input int base);
    for (int i = 0; i < nbeats; i++) begin
      drive_beat(DW'(base + i), DW'($urandom), (i == 0), fac, ph);
      if (gapmax > 0) idle($urandom_range(0, gapmax));
    end
  endtask

  task automatic drain(input string name);
    int unsigned c = 0;
    while ((q.size() != 0 || o_valid) && c < 500) begin
      @(posedge i_clk);
      #1;
      c++;
    end
    checks++;
    if (q.size() != 0 || o_valid) begin
      errors++;
      $display("FAIL drain_%s actual pending=%0d required pending=0", name, q.size());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=still running required=finished");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_rst    = 1'b1;
    i_valid  = 1'b0;
    i_sof    = 1'b0;
    i_re     = '0;
    i_im     = '0;
    i_factor = '0;
    i_phase  = '0;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;

    chk("reset_o_valid", 64'(o_valid), 64'd0);
    chk("reset_o_ready", 64'(o_ready), 64'd1);
    chk("reset_o_sof",   64'(o_sof),   64'd0);
    chk("reset_o_eof",   64'(o_eof),   64'd0);
    chk("reset_o_err",   64'(o_err),   64'd0);
    chk("reset_o_data",  64'({o_re, o_im}), 64'd0);

    // factor 8, phase 0, continuous ramp
    ready_mode = 0;
    idle(1);
    drive_beat(DW'(0), DW'($urandom), 1'b1, 8, 0);
    chk("latency_valid", 64'(o_valid), 64'd1);
    chk("latency_sof",   64'(o_sof),   64'd1);
    chk("latency_re",    64'(o_re),    64'd0);
    for (int i = 1; i < 128; i++) drive_beat(DW'(i), DW'($urandom), 1'b0, 0, 0);
    drain("f8p0");

    // factor 4, phase 3, then a stray non-SOF beat in IDLE
    send_frame(4, 3, 64, 0, 0);
    drain("f4p3");
    drive_beat(DW'(999), DW'(7), 1'b0, 0, 0);
    idle(3);
    chk("idle_drop_valid", 64'(o_valid), 64'd0);
    drain("idle_drop");

    // factor 8, phase 2, toggling ready and input gaps
    ready_mode = 1;
    send_frame(8, 2, 128, 3, 0);
    drain("f8p2_stall");
    ready_mode = 0;

    // SOF mid-frame at beat 50
    ready_mode = 2;
    send_frame(8, 0, 50, 1, 0);
    send_frame(8, 3, 128, 1, 1000);
    drain("resync");
    ready_mode = 0;

    // illegal configurations
    idle(2);
    drive_beat(DW'(1), DW'(1), 1'b1, 0, 0);
    idle(2);
    drive_beat(DW'(2), DW'(2), 1'b1, 4, 5);
    idle(2);
    drive_beat(DW'(3), DW'(3), 1'b1, 9, 0);
    drive_beat(DW'(4), DW'(4), 1'b0, 0, 0);
    idle(3);
    chk("illegal_no_valid", 64'(o_valid), 64'd0);
    drain("illegal");

    // reset while a held output is stalled
    send_frame(8, 6, 70, 0, 0);
    ready_mode = 3;
    idle(2);
    drive_beat(DW'(70), DW'(5), 1'b0, 0, 0);
    chk("stall_valid", 64'(o_valid), 64'd1);
    chk("stall_ready", 64'(o_ready), 64'd0);
    chk("stall_re",    64'(o_re),    64'd70);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    chk("rst_mid_valid", 64'(o_valid), 64'd0);
    chk("rst_mid_ready", 64'(o_ready), 64'd1);
    chk("rst_mid_re",    64'(o_re),    64'd0);
    ready_mode = 2;
    send_frame(2, 1, 32, 1, 500);
    drain("post_reset");
    ready_mode = 0;
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
